clock_monitor: RTL and testbench

//  Receive-side checker for a clock: measures the period of an asynchronous monitored clock in

---
 rtl/clock_monitor_pkg.sv | 17 +
 rtl/bit_synchronizer.sv | 24 ++
 rtl/clock_monitor.sv | 173 +++++++++++++++++
 tb/tb_clock_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types for the clock monitor: FSM state encoding and the period classification.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        TRACK,
        LOCKED
    } clock_monitor_state_e;

    typedef enum logic [1:0] {
        PERIOD_GOOD,
        PERIOD_SHORT,
        PERIOD_LONG
    } period_class_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of an asynchronous clock in clk cycles and checks it against an
// expected period with inclusive tolerance; reports lock and sticky short/long/timeout errors.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] expected_period_i,
    input  logic [CNT_W-1:0] tolerance_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             err_short_o,
    output logic             err_long_o,
    output logic             err_timeout_o
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    clock_monitor_state_e state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic                 period_valid_q, period_valid_d;
    logic                 err_short_q, err_short_d;
    logic                 err_long_q, err_long_d;
    logic                 err_timeout_q, err_timeout_d;

    logic mon_sync;
    logic mon_prev_q;
    logic mon_edge;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_mon_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (mon_clk_i),
        .q_o  (mon_sync)
    );

    assign mon_edge = mon_sync & ~mon_prev_q;

    // Timeout limit 2*expected+tolerance needs two extra bits to never wrap.
    logic [CNT_W+1:0] timeout_limit;
    logic             cnt_sat;
    logic             timeout_hit;

    assign timeout_limit = {1'b0, expected_period_i, 1'b0} + {2'b00, tolerance_i};
    assign cnt_sat       = &cnt_q;
    assign timeout_hit   = ({2'b00, cnt_q} == timeout_limit) && !cnt_sat;

    // Signed distance from the expected period; one spare bit keeps -tolerance representable.
    logic signed [CNT_W+1:0] diff;
    logic signed [CNT_W+1:0] tol_s;
    period_class_e           period_class;

    assign diff  = $signed({2'b00, cnt_q}) - $signed({2'b00, expected_period_i});
    assign tol_s = $signed({2'b00, tolerance_i});

    always_comb begin
        if (diff < -tol_s) begin
            period_class = PERIOD_SHORT;
        end else if (diff > tol_s) begin
            period_class = PERIOD_LONG;
        end else begin
            period_class = PERIOD_GOOD;
        end
    end

    logic set_short, set_long, set_timeout;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_cnt_d     = good_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        set_short      = 1'b0;
        set_long       = 1'b0;
        set_timeout    = 1'b0;

        if (!enable_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d      = '0;
                    good_cnt_d = '0;
                    state_d    = SEEK;
                end
                SEEK: begin
                    if (mon_edge) begin
                        cnt_d   = CNT_W'(1);
                        state_d = TRACK;
                    end
                end
                TRACK, LOCKED: begin
                    cnt_d = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
                    if (mon_edge) begin
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        cnt_d          = CNT_W'(1);
                        if (period_class != PERIOD_GOOD) begin
                            set_short  = (period_class == PERIOD_SHORT);
                            set_long   = (period_class == PERIOD_LONG);
                            good_cnt_d = '0;
                            state_d    = TRACK;
                        end else if (state_q == TRACK) begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                            if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                            end
                        end
                    end else if (timeout_hit) begin
                        set_timeout = 1'b1;
                        cnt_d       = '0;
                        good_cnt_d  = '0;
                        state_d     = SEEK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A flag raised in the same cycle as clear_i stays raised.
        err_short_d   = (err_short_q & ~clear_i) | set_short;
        err_long_d    = (err_long_q & ~clear_i) | set_long;
        err_timeout_d = (err_timeout_q & ~clear_i) | set_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mon_prev_q     <= 1'b0;
            cnt_q          <= '0;
            good_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mon_prev_q     <= mon_sync;
            cnt_q          <= cnt_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            err_short_q    <= err_short_d;
            err_long_q     <= err_long_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;
    assign locked_o       = (state_q == LOCKED);
    assign err_short_o    = err_short_q;
    assign err_long_o     = err_long_q;
    assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: directed scenarios plus randomized periods, all
// checked every clk cycle against an event-level reference model of the monitor.
module tb_clock_monitor;

    localparam int CNT_W      = 16;
    localparam int LOCK_COUNT = 4;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mon_clk;
    logic             enable;
    logic [CNT_W-1:0] exp_p;
    logic [CNT_W-1:0] tol;
    logic             clear;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic             locked_o;
    logic             err_short_o;
    logic             err_long_o;
    logic             err_timeout_o;

    clock_monitor #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mon_clk_i        (mon_clk),
        .enable_i         (enable),
        .expected_period_i(exp_p),
        .tolerance_i      (tol),
        .clear_i          (clear),
        .period_o         (period_o),
        .period_valid_o   (period_valid_o),
        .locked_o         (locked_o),
        .err_short_o      (err_short_o),
        .err_long_o       (err_long_o),
        .err_timeout_o    (err_timeout_o)
    );

    always #1 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle time %0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference model: tracks time since the last accepted mon_clk rise and applies the
    // period rules to each rise as the monitor sees it, three clk cycles after it occurs.
    int n = 0;
    int rise_q[$];
    bit m_active, m_armed, m_locked, m_valid, m_es, m_el, m_et;
    int m_since, m_good, m_period;

    task automatic model_reset();
        m_active = 0; m_armed = 0; m_locked = 0; m_valid = 0;
        m_es = 0; m_el = 0; m_et = 0;
        m_since = 0; m_good = 0; m_period = 0;
        rise_q.delete();
    endtask

    task automatic tick();
        bit det, s_s, s_l, s_t;
        int meas, limit;
        @(negedge clk);
        n++;
        det = (rise_q.size() > 0) && (rise_q[0] == n);
        if (det) void'(rise_q.pop_front());
        s_s = 0; s_l = 0; s_t = 0;
        m_valid = 0;
        limit = 2 * int'(exp_p) + int'(tol);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!enable) begin
                m_active = 0; m_armed = 0; m_locked = 0; m_good = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (!m_armed) begin
                if (det) begin
                    m_armed = 1;
                    m_since = 0;
                end
            end else begin
                m_since++;
                if (det) begin
                    meas = (m_since > SAT) ? SAT : m_since;
                    m_period = meas;
                    m_valid = 1;
                    m_since = 0;
                    if (meas + int'(tol) < int'(exp_p)) s_s = 1;
                    else if (meas > int'(exp_p) + int'(tol)) s_l = 1;
                    if (s_s || s_l) begin
                        m_good = 0;
                        m_locked = 0;
                    end else if (!m_locked) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) m_locked = 1;
                    end
                end else if (m_since == limit && limit < SAT) begin
                    s_t = 1;
                    m_locked = 0;
                    m_good = 0;
                    m_armed = 0;
                end
            end
            if (clear) begin
                m_es = 0; m_el = 0; m_et = 0;
            end
            m_es |= s_s;
            m_el |= s_l;
            m_et |= s_t;
        end
        check("period_valid", period_valid_o, m_valid);
        check("period", period_o, m_period);
        check("locked", locked_o, m_locked);
        check("err_short", err_short_o, m_es);
        check("err_long", err_long_o, m_el);
        check("err_timeout", err_timeout_o, m_et);
    endtask

    // One monitored period of p clk cycles, starting with a rise at the current negedge.
    task automatic mon_period(input int p, input bit clr_at_edge);
        mon_clk = 1'b1;
        rise_q.push_back(n + 3);
        for (int i = 1; i <= p; i++) begin
            tick();
            if (clr_at_edge && i == 2) clear = 1'b1;
            if (clr_at_edge && i == 3) clear = 1'b0;
            if (i == p / 2) mon_clk = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int e, t, r, p;
        rst_n = 1'b0; mon_clk = 1'b0; enable = 1'b0; clear = 1'b0;
        exp_p = 16'd10; tol = 16'd1;
        model_reset();
        idle(3);
        check("reset_locked", locked_o, 0);
        check("reset_period", period_o, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: period 10, expected 10 +/- 1: locks after four good periods.
        enable = 1'b1;
        idle(3);
        for (int k = 0; k < 4; k++) mon_period(10, 0);
        check("t1_unlocked_after_3_periods", locked_o, 0);
        mon_period(10, 0);
        check("t1_locked_after_4_periods", locked_o, 1);
        check("t1_period", period_o, 10);

        // 2: one short period of 8 breaks lock; four good periods relock.
        mon_period(8, 0);
        mon_period(10, 0);
        check("t2_period_short", period_o, 8);
        check("t2_err_short", err_short_o, 1);
        check("t2_unlocked", locked_o, 0);
        for (int k = 0; k < 3; k++) mon_period(10, 0);
        check("t2_not_yet_relocked", locked_o, 0);
        mon_period(10, 0);
        check("t2_relocked", locked_o, 1);

        // 3: mon_clk stops; timeout 21 cycles after the last seen rise (seen 3 cycles after it).
        idle(13);
        check("t3_no_timeout_at_20", err_timeout_o, 0);
        idle(1);
        check("t3_timeout_at_21", err_timeout_o, 1);
        check("t3_unlocked", locked_o, 0);
        idle(5);
        mon_period(10, 0);
        check("t3_rearm_period_unchanged", period_o, 10);
        mon_period(10, 0);

        // 4: tolerance is inclusive at 11 and 9; 12 is long.
        pulse_clear();
        mon_period(11, 0);
        mon_period(9, 0);
        mon_period(12, 0);
        check("t4_no_err_short", err_short_o, 0);
        check("t4_no_err_long", err_long_o, 0);
        mon_period(10, 0);
        check("t4_err_long", err_long_o, 1);
        check("t4_period_12", period_o, 12);

        // 5: clear coincident with a bad period loses to the set; clear alone wins.
        pulse_clear();
        check("t5_cleared", err_long_o, 0);
        mon_period(13, 0);
        mon_period(10, 1);
        check("t5_set_beats_clear", err_long_o, 1);
        pulse_clear();
        check("t5_clear_alone", err_long_o, 0);

        // 6: enable drop while locked keeps sticky errors; reset mid-TRACK clears all.
        mon_period(7, 0);
        for (int k = 0; k < 6; k++) mon_period(10, 0);
        check("t6_locked", locked_o, 1);
        check("t6_err_short_held", err_short_o, 1);
        enable = 1'b0;
        tick();
        check("t6_disable_unlock", locked_o, 0);
        check("t6_sticky_survives", err_short_o, 1);
        mon_period(10, 0);
        mon_period(10, 0);
        enable = 1'b1;
        idle(3);
        for (int k = 0; k < 3; k++) mon_period(10, 0);
        rst_n = 1'b0;
        tick();
        check("t6_reset_err_short", err_short_o, 0);
        check("t6_reset_period", period_o, 0);
        rst_n = 1'b1;
        idle(3);

        // Randomized: fresh expected/tolerance per run, mostly good periods with bad and stalls.
        for (int it = 0; it < 30; it++) begin
            enable = 1'b0;
            tick();
            e = $urandom_range(10, 16);
            t = $urandom_range(0, 2);
            exp_p = 16'(e);
            tol = 16'(t);
            pulse_clear();
            enable = 1'b1;
            idle(2);
            for (int k = 0; k < 10; k++) begin
                r = $urandom_range(0, 11);
                if (r < 8) p = $urandom_range(e - t, e + t);
                else if (r == 8) p = e - t - 1 - $urandom_range(0, 2);
                else if (r == 9) p = e + t + 1 + $urandom_range(0, 3);
                else if (r == 10) p = 2 * e + t;
                else p = 2 * e + t + 1 + $urandom_range(0, 5);
                mon_period(p, $urandom_range(0, 7) == 0);
            end
            idle(4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
